if_fetch_unit: RTL and testbench

//   Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC,

---
 rtl/rv_fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and constants for the instruction-fetch stage.
//   XLEN/ILEN   address and instruction widths
//   NOP_INSTR   word presented when no real instruction is available (addi x0,x0,0)
//   PC_STEP     sequential PC increment
//   fetch_entry_t  {pc, instr} pair buffered between memory and the IF/ID register
package rv_fetch_pkg;

    localparam int              XLEN      = 32;
    localparam int              ILEN      = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low two address bits are discarded.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t (DEPTH a power of 2).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            empties the FIFO; wins over a simultaneous push or pop
//   push, push_data  write one entry (accepted when not full, or when full with a pop)
//   pop              retire the head entry (ignored when empty)
//   head             oldest entry, meaningful only when !empty
//   count/empty/full occupancy status
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only read after count marks it valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the fetch PC, issues in-order requests over req/gnt/rvalid, buffers returned
// words with their PCs and presents {PC_IF, INSTR_IF}. Redirects flush stale fetches.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pc_write                   1 = IF/ID takes the presented word, 0 = stall
//   pc_src, pc_target          redirect strobe and target (bits [1:0] ignored)
//   imem_req/addr/gnt          request channel (addr word aligned)
//   imem_rvalid/rdata          in-order response channel
//   PC_IF, INSTR_IF, instr_valid  presented instruction (NOP when not valid)
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt (words presented and popped)
// and perf_stall_cnt (cycles with instr_valid=0 or pc_write=0).
module if_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC_IF,
    output logic [ILEN-1:0] INSTR_IF,
    output logic            instr_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW:0]     occupancy;
    logic            issue, drop;
    logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head, fifo_wdata;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (pc_src),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        instr_valid = !fifo_empty;
        PC_IF       = instr_valid ? fifo_head.pc    : last_pc_q;
        INSTR_IF    = instr_valid ? fifo_head.instr : NOP_INSTR;
        fifo_pop    = pc_write && instr_valid;

        // Credits cover both in-flight requests and buffered words; a pop this cycle
        // already frees its slot, which lets a 1-cycle memory stream without bubbles.
        occupancy = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};
        imem_req  = !reset && !pc_src && (occupancy < (CW+1)'(DEPTH));
        imem_addr = fetch_pc_q;
        issue     = imem_req && imem_gnt;

        drop       = imem_rvalid && (discard_q != '0);
        fifo_push  = imem_rvalid && !drop;
        fifo_wdata = '{pc: resp_pc_q, instr: imem_rdata};

        fetch_pc_d    = issue     ? fetch_pc_q + PC_STEP : fetch_pc_q;
        resp_pc_d     = fifo_push ? resp_pc_q + PC_STEP  : resp_pc_q;
        last_pc_d     = PC_IF;
        discard_d     = drop ? discard_q - CW'(1) : discard_q;
        outstanding_d = outstanding_q;
        if (issue)       outstanding_d = outstanding_d + CW'(1);
        if (imem_rvalid) outstanding_d = outstanding_d - CW'(1);

        if (pc_src) begin
            fetch_pc_d = align_word(pc_target);
            resp_pc_d  = align_word(pc_target);
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            last_pc_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            last_pc_q     <= last_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + {31'b0, fifo_pop};
        perf_stall_cnt_d = perf_stall_cnt_q + {31'b0, (!instr_valid || !pc_write)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // Memory must never answer a request that was not issued.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (outstanding_q == '0)));
    // Credit accounting guarantees a returning word always has a buffer slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios followed by randomized traffic for if_fetch_unit.
// A behavioural memory answers requests in order with a chosen latency; a reference
// model tracks the expected instruction stream (next PC to present, next fetch address,
// buffered word count, requests made stale by redirects).
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, pc_write, pc_src;
    logic [31:0] pc_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_IF, INSTR_IF;
    logic        instr_valid;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC_IF       (PC_IF),
        .INSTR_IF    (INSTR_IF),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc, lat, n_checks, n_errors, buf_cnt;
    logic [31:0] exp_pc, exp_fetch, last_seen;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        pc_target   = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_req", 32'(imem_req), 32'(1'b0));
            if (i == 1) begin
                check("rst_addr", imem_addr, RESET_PC);
                check("rst_pc_if", PC_IF, 32'h0);
                check("rst_instr", INSTR_IF, NOP);
                check("rst_valid", 32'(instr_valid), 32'(1'b0));
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        mq.delete();
        buf_cnt   = 0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        last_seen = '0;
    endtask

    // One clock cycle: memory drives its response, outputs are checked at the falling
    // edge against the model, then the model advances past the rising edge.
    task automatic cycle();
        bit          acc, popped, pushed;
        logic [31:0] tgt;
        pushed = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            pushed      = !mq[0].stale;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = PC_IF;
        s_instr = INSTR_IF;

        check("imem_addr", s_addr, exp_fetch);
        check("instr_valid", 32'(s_valid), 32'(buf_cnt > 0));
        if (buf_cnt > 0) begin
            check("pc_if", s_pc, exp_pc);
            check("instr_if", s_instr, mem_word(exp_pc));
        end else begin
            check("instr_if_nop", s_instr, NOP);
            check("pc_if_hold", s_pc, last_seen);
        end
        if (pc_src) check("req_in_redirect", 32'(s_req), 32'(1'b0));
        check("occupancy_bound", 32'(mq.size() + buf_cnt <= DEPTH), 32'(1'b1));

        acc    = s_req && imem_gnt;
        popped = pc_write && (buf_cnt > 0);
        tgt    = {pc_target[31:2], 2'b00};
        if (buf_cnt > 0) last_seen = exp_pc;
        if (popped) exp_pc = exp_pc + 32'd4;
        if (acc) exp_fetch = exp_fetch + 32'd4;

        @(posedge clk);
        #1;
        if (imem_rvalid) void'(mq.pop_front());
        if (acc) mq.push_back('{addr: s_addr, due: cyc + lat, stale: 1'b0});
        buf_cnt = buf_cnt - int'(popped) + int'(pushed);
        if (pc_src) begin
            buf_cnt   = 0;
            exp_pc    = tgt;
            exp_fetch = tgt;
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        lat      = 1;
        buf_cnt  = 0;

        // 1: streaming with a 1-cycle memory
        apply_reset();
        imem_gnt = 1'b1;
        pc_write = 1'b1;
        lat      = 1;
        repeat (4) cycle();
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t1_steady_valid", 32'(s_valid), 32'(1'b1));
            check("t1_pc", s_pc, 32'h8 + 32'(4 * i));
        end

        // 2: stall while PC 0x8 is presented
        apply_reset();
        imem_gnt = 1'b1;
        pc_write = 1'b1;
        lat      = 1;
        repeat (4) cycle();
        pc_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_hold_pc", s_pc, 32'h8);
            check("t2_hold_instr", s_instr, mem_word(32'h8));
            if (i >= 1) check("t2_req_drop", 32'(s_req), 32'(1'b0));
        end
        pc_write = 1'b1;
        cycle();
        check("t2_resume_req", 32'(s_req), 32'(1'b1));
        check("t2_resume_addr", s_addr, 32'h10);

        // 3: redirect to 0x103 with two requests in flight
        apply_reset();
        imem_gnt = 1'b1;
        pc_write = 1'b1;
        lat      = 3;
        repeat (2) cycle();
        pc_src    = 1'b1;
        pc_target = 32'h0000_0103;
        cycle();
        check("t3_req_redirect", 32'(s_req), 32'(1'b0));
        pc_src = 1'b0;
        cycle();
        check("t3_next_addr", s_addr, 32'h100);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_valid) break;
        end
        check("t3_valid_seen", 32'(s_valid), 32'(1'b1));
        check("t3_first_pc", s_pc, 32'h100);

        // 4: grant withheld
        apply_reset();
        imem_gnt = 1'b0;
        pc_write = 1'b1;
        lat      = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_req", 32'(s_req), 32'(1'b1));
            check("t4_addr", s_addr, RESET_PC);
            check("t4_valid", 32'(s_valid), 32'(1'b0));
            check("t4_instr", s_instr, NOP);
        end

        // 5: redirect coincident with gnt and rvalid, target near the top of memory
        apply_reset();
        imem_gnt = 1'b1;
        pc_write = 1'b1;
        lat      = 2;
        repeat (2) cycle();
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFA;
        cycle();
        check("t5_req_redirect", 32'(s_req), 32'(1'b0));
        pc_src = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_valid) break;
        end
        check("t5_valid_seen", 32'(s_valid), 32'(1'b1));
        check("t5_first_pc", s_pc, 32'hFFFF_FFF8);
        repeat (12) cycle();

        // 6 and random traffic: stalls, redirects, variable latency, mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                imem_gnt  = ($urandom_range(0, 3) != 0);
                pc_write  = ($urandom_range(0, 4) != 0);
                pc_src    = ($urandom_range(0, 19) == 0);
                pc_target = $urandom;
                lat       = $urandom_range(1, 4);
                cycle();
            end
        end
        apply_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
